// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, data and shared memory port signals of the arbiter.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        i_stall;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        d_stall;

    logic        err;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_valid, i_stall, d_rdata, d_valid, d_stall, err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data requests onto one shared memory port,
// alternating grants on contention and aborting accesses that never complete.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

    localparam logic [7:0] WaitMax = 8'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        last_d_q, last_d_d;  // 1 when the data side won the previous grant
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [7:0]  wait_q, wait_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_valid_q, i_valid_d;
    logic        d_valid_q, d_valid_d;
    logic        err_q, err_d;

    logic i_pend, d_pend, grant_d, timed_out, mem_req;

    // A requester whose completion is still being signalled is not re-granted.
    assign i_pend  = bus.i_req & ~i_valid_q;
    assign d_pend  = bus.d_req & ~d_valid_q;
    assign grant_d = d_pend & (~i_pend | ~last_d_q);

    always_comb begin
        state_d   = state_q;
        last_d_d  = last_d_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        wait_d    = wait_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_valid_d = 1'b0;
        d_valid_d = 1'b0;
        err_d     = 1'b0;
        timed_out = 1'b0;

        case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d  = StDacc;
                    last_d_d = 1'b1;
                    addr_d   = bus.d_addr;
                    we_d     = bus.d_we;
                    wdata_d  = bus.d_wdata;
                    wait_d   = 8'd0;
                end else if (i_pend) begin
                    state_d  = StIacc;
                    last_d_d = 1'b0;
                    addr_d   = bus.i_addr;
                    we_d     = 1'b0;
                    wdata_d  = 32'd0;
                    wait_d   = 8'd0;
                end
            end
            StIacc, StDacc: begin
                // A ready arriving on the timeout cycle still wins as a normal completion.
                if (bus.mem_ready || (wait_q == WaitMax)) begin
                    timed_out = ~bus.mem_ready;
                    state_d   = StIdle;
                    wait_d    = 8'd0;
                    err_d     = timed_out;
                    if (state_q == StIacc) begin
                        i_valid_d = 1'b1;
                        i_rdata_d = timed_out ? 32'd0 : bus.mem_rdata;
                    end else begin
                        d_valid_d = 1'b1;
                        if (timed_out) begin
                            d_rdata_d = 32'd0;
                        end else if (!we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            last_d_q  <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            we_q      <= 1'b0;
            wait_q    <= 8'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            wait_q    <= wait_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            err_q     <= err_d;
        end
    end

    assign mem_req       = (state_q != StIdle);
    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = we_q & mem_req;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.i_rdata = i_rdata_q;
    assign bus.i_valid = i_valid_q;
    assign bus.i_stall = bus.i_req & ~i_valid_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_valid = d_valid_q;
    assign bus.d_stall = bus.d_req & ~d_valid_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, arbitration, store, timeout and reset scenarios.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT_CYC(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check1(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called in the first access cycle: checks the port, answers with ready, steps one edge.
    task automatic serve(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] rdata);
        check1({tag, "_mem_req"}, bus.mem_req, 1'b1);
        check32({tag, "_mem_addr"}, bus.mem_addr, addr);
        check1({tag, "_mem_we"}, bus.mem_we, we);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rdata;
        cyc();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check1("valid_excl", bus.i_valid & bus.d_valid, 1'b0);
            check1("i_stall", bus.i_stall, bus.i_req & ~bus.i_valid);
            check1("d_stall", bus.d_stall, bus.d_req & ~bus.d_valid);
        end
    end

    initial begin
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.i_addr    = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;
        cyc();
        cyc();
        mon_en = 1'b1;

        check1("rst_mem_req", bus.mem_req, 1'b0);
        check1("rst_i_valid", bus.i_valid, 1'b0);
        check1("rst_d_valid", bus.d_valid, 1'b0);
        check1("rst_err", bus.err, 1'b0);
        check32("rst_i_rdata", bus.i_rdata, 32'd0);
        check32("rst_d_rdata", bus.d_rdata, 32'd0);

        // Single fetch at minimum latency
        rst        = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0040_0000;
        cyc();
        serve("fetch", 32'h0040_0000, 1'b0, 32'h8C08_0004);
        check1("fetch_i_valid", bus.i_valid, 1'b1);
        check1("fetch_d_valid", bus.d_valid, 1'b0);
        check1("fetch_err", bus.err, 1'b0);
        check32("fetch_i_rdata", bus.i_rdata, 32'h8C08_0004);
        check1("fetch_idle", bus.mem_req, 1'b0);
        bus.i_req = 1'b0;
        cyc();
        check1("fetch_pulse_end", bus.i_valid, 1'b0);
        check32("fetch_i_rdata_hold", bus.i_rdata, 32'h8C08_0004);

        // Contention after reset: data first, then strict alternation
        rst = 1'b1;
        cyc();
        rst        = 1'b0;
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0000_0100;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_0200;
        cyc();
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                serve("arb_d", 32'h0000_0200, 1'b0, 32'hD000_0000 + 32'(k));
                check1("arb_d_valid", bus.d_valid, 1'b1);
                check1("arb_d_ival", bus.i_valid, 1'b0);
                check32("arb_d_rdata", bus.d_rdata, 32'hD000_0000 + 32'(k));
            end else begin
                serve("arb_i", 32'h0000_0100, 1'b0, 32'hA000_0000 + 32'(k));
                check1("arb_i_valid", bus.i_valid, 1'b1);
                check1("arb_i_dval", bus.d_valid, 1'b0);
                check32("arb_i_rdata", bus.i_rdata, 32'hA000_0000 + 32'(k));
            end
            if (k == 3) begin
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end
            cyc();
        end
        check1("arb_done_idle", bus.mem_req, 1'b0);

        // Store with ready delayed 3 cycles; requester drops d_req mid-access
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h1001_0000;
        bus.d_wdata = 32'hDEAD_BEEF;
        cyc();
        for (int c = 0; c < 4; c++) begin
            check1("st_mem_req", bus.mem_req, 1'b1);
            check32("st_mem_addr", bus.mem_addr, 32'h1001_0000);
            check1("st_mem_we", bus.mem_we, 1'b1);
            check32("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
            check1("st_no_early_valid", bus.d_valid, 1'b0);
            if (c == 1) bus.d_req = 1'b0;
            if (c == 3) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'h5555_5555;
            end
            cyc();
        end
        check1("st_d_valid", bus.d_valid, 1'b1);
        check1("st_err", bus.err, 1'b0);
        check32("st_d_rdata_kept", bus.d_rdata, 32'hD000_0002);
        check1("st_idle", bus.mem_req, 1'b0);
        // mem_ready left high through an idle cycle must be ignored
        cyc();
        check1("idle_ready_d", bus.d_valid, 1'b0);
        check1("idle_ready_i", bus.i_valid, 1'b0);
        check1("idle_ready_req", bus.mem_req, 1'b0);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;

        // Data load that never completes
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_2000;
        cyc();
        for (int c = 0; c < 16; c++) begin
            check1("to_mem_req", bus.mem_req, 1'b1);
            check1("to_no_valid", bus.d_valid, 1'b0);
            cyc();
        end
        check1("to_d_valid", bus.d_valid, 1'b1);
        check1("to_err", bus.err, 1'b1);
        check32("to_d_rdata", bus.d_rdata, 32'd0);
        check1("to_idle", bus.mem_req, 1'b0);
        bus.d_req = 1'b0;
        cyc();
        check1("to_pulse_end", bus.d_valid, 1'b0);
        check1("to_err_end", bus.err, 1'b0);

        // Ready on the exact timeout cycle is a normal completion
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0040_0008;
        cyc();
        for (int c = 0; c < 16; c++) begin
            check1("tie_mem_req", bus.mem_req, 1'b1);
            if (c == 15) begin
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'hCAFE_F00D;
            end
            cyc();
        end
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'd0;
        check1("tie_i_valid", bus.i_valid, 1'b1);
        check1("tie_err", bus.err, 1'b0);
        check32("tie_i_rdata", bus.i_rdata, 32'hCAFE_F00D);
        bus.i_req = 1'b0;
        cyc();

        // Reset in the middle of a data access
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h0000_3000;
        cyc();
        check1("rm_mem_req", bus.mem_req, 1'b1);
        cyc();
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        bus.d_req = 1'b0;
        check1("rm_mem_req_drop", bus.mem_req, 1'b0);
        check1("rm_no_d_valid", bus.d_valid, 1'b0);
        check32("rm_d_rdata", bus.d_rdata, 32'd0);
        check32("rm_i_rdata", bus.i_rdata, 32'd0);
        cyc();
        check1("rm_no_d_valid2", bus.d_valid, 1'b0);
        check1("rm_idle2", bus.mem_req, 1'b0);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h0040_0004;
        cyc();
        serve("rm_fetch", 32'h0040_0004, 1'b0, 32'h2402_000A);
        check1("rm_fetch_valid", bus.i_valid, 1'b1);
        check1("rm_fetch_err", bus.err, 1'b0);
        check32("rm_fetch_rdata", bus.i_rdata, 32'h2402_000A);
        bus.i_req = 1'b0;
        cyc();
        check1("rm_fetch_pulse_end", bus.i_valid, 1'b0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16, cycles without mem_ready before an access is aborted (range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 i_req  input  1  instruction-fetch request; held until i_valid.
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_rdata  output  32  fetched word, registered.
REQ-007 i_valid  output  1  one-cycle fetch-completion pulse.
REQ-008 i_stall  output  1  fetch stage stall.
REQ-009 d_req  input  1  data request; held until d_valid.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr / d_wdata  input  32 / 32  data address / store data.
REQ-012 d_rdata  output  32  load data, registered.
REQ-013 d_valid  output  1  one-cycle data-completion pulse.
REQ-014 d_stall  output  1  memory stage stall.
REQ-015 err  output  1  with i_valid or d_valid, marks a timed-out access.
REQ-016 mem_req / mem_we  output  1 / 1  shared-port request / write enable.
REQ-017 mem_addr / mem_wdata  output  32 / 32  shared-port address / write data.
REQ-018 mem_rdata / mem_ready  input  32 / 1  shared-port read data / completion.

Function
REQ-019 FSM states: IDLE, IACC, DACC; the block serialises both requesters onto one memory port.
REQ-020 IDLE: mem_req = 0; sample i_req, d_req; ignore any requester whose valid is high this cycle.
REQ-021 IDLE, one requester pending: go to its ACC state next cycle; latch its address, we, and wdata. Fetches latch we = 0.
REQ-022 IDLE, both pending: grant the requester not granted last (last_grant register). On tie after reset, data wins.
REQ-023 IACC/DACC: mem_req = 1; mem_addr, mem_we, mem_wdata come from latched registers and stay stable until completion.
REQ-024 Completion is mem_ready = 1 while in IACC/DACC.
REQ-025 On completion, next cycle: state = IDLE; the matching valid pulses for exactly one cycle; err = 0.
REQ-026 Read completion: the matching rdata register captures mem_rdata on that cycle and holds it until the next completion.
REQ-027 Store completion: d_rdata is unchanged.
REQ-028 Minimum latency: req seen in IDLE at cycle N, mem_ready at N+1, valid at N+2.
REQ-029 Wait counter: cleared on ACC entry; increments each ACC cycle with mem_ready = 0.
REQ-030 Timeout: when the wait counter reaches TIMEOUT_CYC-1 with mem_ready = 0, abort the access. Next cycle: IDLE, matching valid = 1, err = 1, matching rdata = 0.
REQ-031 mem_ready outside IACC/DACC is ignored.
REQ-032 mem_ready arriving in the same cycle as the timeout condition counts as a normal completion (err = 0).
REQ-033 i_stall = i_req & ~i_valid and d_stall = d_req & ~d_valid (combinational).
REQ-034 A requester dropping its req mid-access does not cancel the access; the valid pulse is still issued.
REQ-035 At most one of i_valid and d_valid is high in any cycle.

Reset
REQ-036 rst = 1 at a rising edge forces: state IDLE; last_grant = I; wait counter 0; mem_req 0; i_valid, d_valid, err 0; i_rdata, d_rdata 0.
REQ-037 Reset mid-access drops mem_req the next cycle and produces no valid pulse.

Verification
REQ-038 Single fetch: i_req, i_addr=0x00400000, mem_ready one cycle later with mem_rdata=0x8C080004 -> i_valid 2 cycles after req; i_rdata=0x8C080004; err=0.
REQ-039 Simultaneous i_req and d_req after reset -> DACC first; then IACC. Repeat with both held -> grants alternate D, I, D, I.
REQ-040 Store: d_we=1, d_addr=0x10010000, d_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_* stable for 4 cycles; d_valid once; d_rdata unchanged.
REQ-041 Timeout: mem_ready held 0, TIMEOUT_CYC=16 -> mem_req high 16 cycles; then d_valid=1, err=1, d_rdata=0; state IDLE.
REQ-042 Reset mid-DACC -> mem_req=0 next cycle; no d_valid. A subsequent i_req is served normally.
REQ-043 Check every cycle: i_valid & d_valid never both 1; stall equations per REQ-033 hold.
